tq_trans_seq: RTL
=================

# tq_trans_seq

Sequencer for the two-pass (row, then column) transform datapath in the tq path. It latches the transform size and direction for one block, drives the enable/inverse controls of the premutation stages, and counts rows through the row pass and then the column pass. It also handshakes with the transpose memory between passes and tracks in-flight rows through a fixed-latency datapath so it can flag output validity and block completion.

## Interface
Parameters:
- LAT, 4, datapath latency in cycles from row issue to row output; legal range 1..8.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- i_start  in  1  block start pulse; sampled only in IDLE.
- i_size  in  2  transform size: 0=4x4, 1=8x8, 2=16x16, 3=32x32; sampled with i_start.
- i_inverse  in  1  1=inverse transform; sampled with i_start.
- i_valid  in  1  row-pass input row present.
- i_tm_ready  in  1  transpose memory holds a full block for the column pass.
- o_ready  out  1  row-pass input accepted when i_valid&o_ready.
- o_busy  out  1  block in progress (any state except IDLE).
- o_pass  out  1  0=row pass, 1=column pass.
- o_en8 / o_en16 / o_en32  out  1 each  premutation stage enables.
- o_inverse  out  1  latched direction to all premutation stages.
- o_tm_rd  out  1  transpose-memory read strobe for the column pass.
- o_row_idx  out  5  index of the row issued this cycle.
- o_valid  out  1  datapath output row valid.
- o_out_idx  out  5  index of the row leaving the datapath.
- o_done  out  1  one-cycle block-complete pulse.

## Operation
- N = 4<<size_q, where size_q is the latched i_size.
- Decode of size_q: o_en8=(size_q>=1), o_en16=(size_q>=2), o_en32=(size_q==3).
- size_q, o_inverse and the enables hold from the cycle after an accepted start until the next accepted start. They are not cleared on DONE.
- States:
  - IDLE: if i_start, latch config and go to ROW.
  - ROW: o_ready=1. Each i_valid cycle issues row o_row_idx (0..N-1, incrementing on accept). Accepting row N-1 goes to DRAIN_R.
  - DRAIN_R: LAT cycles with no issue, then go to WAIT_TM.
  - WAIT_TM: when i_tm_ready=1, go to COL.
  - COL: o_pass=1, o_tm_rd=1 every cycle, rows 0..N-1 in N consecutive cycles with no stall. After row N-1 go to DRAIN_C.
  - DRAIN_C: LAT cycles, then go to DONE.
  - DONE: o_done=1 for one cycle, then go to IDLE.
- Issue tracking: an issue is a row accept in ROW or a cycle of o_tm_rd. Issues feed a LAT-deep {valid, idx} shift register, whose tail drives o_valid/o_out_idx.
- o_pass reflects the current state and is 1 in COL, DRAIN_C and DONE.
- Counters are 5 bits and clear on every pass entry. There is no wrap; the index terminates at N-1.

## Timing
- Reset values: all outputs 0; state IDLE; shift register cleared; size_q=0. Asserting rst_n low mid-block aborts immediately; no o_done and no further o_valid follow.
- Start at cycle T: o_busy=1 and o_ready=1 from T+1.
- Row accepted at cycle t gives o_valid=1 at t+LAT with the same index. Issue-to-output latency is exactly LAT, and back-to-back issues give back-to-back outputs.
- Last row-pass accept at t: o_ready=0 from t+1, WAIT_TM entered at t+LAT+1.
- i_tm_ready seen in WAIT_TM at cycle w: o_tm_rd covers w+1..w+N.
- Last column issue at c: final o_valid at c+LAT, o_done at c+LAT+1, o_busy=0 from c+LAT+2.
- Boundary cases:
  - i_start while busy is ignored, and the config does not change.
  - i_valid outside ROW is ignored.
  - i_tm_ready outside WAIT_TM is ignored.
  - i_tm_ready already high when WAIT_TM is entered advances on that cycle.
  - i_start in the cycle after DONE (i.e. in IDLE) is accepted normally.

## Test plan
- Reset check: with LAT=4, reset then idle: every output 0. Start size=3, inverse=1: o_en8/16/32=1/1/1, o_inverse=1 from T+1.
- Size=0, continuous i_valid, i_tm_ready tied 1: row idx 0..3, o_valid at +4 each, four o_tm_rd cycles. o_done exactly 1 cycle at lastcol+5; total 4+4+1+4+4+1 cycles of busy.
- Size=1 with i_valid toggling 1,0,1,0…: exactly 8 accepts, idx contiguous 0..7, o_valid gaps mirror input gaps.
- Size=2, i_tm_ready held 0 for 20 cycles after drain: FSM waits in WAIT_TM, o_tm_rd=0 throughout; then 16 consecutive reads.
- Start asserted during COL with a different size: ignored, enables unchanged, o_done count=1.
- rst_n low at row 10 of a 32x32 block: all outputs 0 asynchronously, no stray o_valid after release, and a fresh start completes normally.

Source files
------------

// File: rtl/tq_trans_seq.sv
// tq_trans_seq: sequencer for the two-pass (row, then column) transform datapath.
// It latches the block size and direction, counts rows through both passes, waits
// for the transpose memory between passes, and tracks in-flight rows through a
// fixed-latency datapath to produce output valid/index and a block-done pulse.
`timescale 1ns/1ps

module tq_trans_seq #(
    parameter int LAT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_start,
    input  logic [1:0] i_size,
    input  logic       i_inverse,
    input  logic       i_valid,
    input  logic       i_tm_ready,
    output logic       o_ready,
    output logic       o_busy,
    output logic       o_pass,
    output logic       o_en8,
    output logic       o_en16,
    output logic       o_en32,
    output logic       o_inverse,
    output logic       o_tm_rd,
    output logic [4:0] o_row_idx,
    output logic       o_valid,
    output logic [4:0] o_out_idx,
    output logic       o_done
);

    typedef enum logic [2:0] {
        IDLE,
        ROW,
        DRAIN_R,
        WAIT_TM,
        COL,
        DRAIN_C,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [1:0] size_q;
    logic       inv_q;
    logic [4:0] cnt;
    logic [2:0] dcnt;
    logic [4:0] last_idx;
    logic       dcnt_last;
    logic       issue;
    logic       cfg_load;
    logic       cnt_clr;
    logic       cnt_inc;
    logic       dcnt_clr;
    logic       dcnt_inc;

    logic [LAT-1:0]      pipe_v;
    logic [LAT-1:0][4:0] pipe_idx;

    assign dcnt_last = (dcnt == 3'(LAT - 1));

    assign o_busy    = (state != IDLE);
    assign o_en8     = (size_q != 2'd0);
    assign o_en16    = size_q[1];
    assign o_en32    = &size_q;
    assign o_inverse = inv_q;
    assign o_valid   = pipe_v[LAT-1];
    assign o_out_idx = pipe_idx[LAT-1];

    // Index of the last row in a pass, derived from the latched block size.
    always_comb begin
        last_idx = 5'd31;
        case (size_q)
            2'd0:    last_idx = 5'd3;
            2'd1:    last_idx = 5'd7;
            2'd2:    last_idx = 5'd15;
            default: last_idx = 5'd31;
        endcase
    end

    // State register; an asynchronous reset aborts any block in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode plus per-state outputs and counter controls.
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        cfg_load  = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        dcnt_clr  = 1'b0;
        dcnt_inc  = 1'b0;
        o_ready   = 1'b0;
        o_pass    = 1'b0;
        o_tm_rd   = 1'b0;
        o_done    = 1'b0;
        o_row_idx = 5'd0;
        case (state)
            IDLE: begin
                if (i_start) begin
                    cfg_load  = 1'b1;
                    cnt_clr   = 1'b1;
                    state_nxt = ROW;
                end
            end
            ROW: begin
                o_ready   = 1'b1;
                o_row_idx = cnt;
                if (i_valid) begin
                    issue = 1'b1;
                    if (cnt == last_idx) begin
                        dcnt_clr  = 1'b1;
                        state_nxt = DRAIN_R;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            DRAIN_R: begin
                if (dcnt_last) begin
                    state_nxt = WAIT_TM;
                end else begin
                    dcnt_inc = 1'b1;
                end
            end
            WAIT_TM: begin
                if (i_tm_ready) begin
                    cnt_clr   = 1'b1;
                    state_nxt = COL;
                end
            end
            COL: begin
                o_pass    = 1'b1;
                o_tm_rd   = 1'b1;
                o_row_idx = cnt;
                issue     = 1'b1;
                if (cnt == last_idx) begin
                    dcnt_clr  = 1'b1;
                    state_nxt = DRAIN_C;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            DRAIN_C: begin
                o_pass = 1'b1;
                if (dcnt_last) begin
                    state_nxt = DONE;
                end else begin
                    dcnt_inc = 1'b1;
                end
            end
            DONE: begin
                o_pass    = 1'b1;
                o_done    = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Block configuration, held until the next accepted start (not cleared on done).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            size_q <= 2'd0;
            inv_q  <= 1'b0;
        end else if (cfg_load) begin
            size_q <= i_size;
            inv_q  <= i_inverse;
        end
    end

    // Row counter (cleared on each pass entry) and drain-cycle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= 5'd0;
            dcnt <= 3'd0;
        end else begin
            if (cnt_clr) begin
                cnt <= 5'd0;
            end else if (cnt_inc) begin
                cnt <= cnt + 5'd1;
            end
            if (dcnt_clr) begin
                dcnt <= 3'd0;
            end else if (dcnt_inc) begin
                dcnt <= dcnt + 3'd1;
            end
        end
    end

    // LAT-deep {valid, idx} delay line mirroring rows travelling through the datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_v   <= '0;
            pipe_idx <= '0;
        end else begin
            pipe_v[0]   <= issue;
            pipe_idx[0] <= issue ? cnt : 5'd0;
            for (int i = 1; i < LAT; i++) begin
                pipe_v[i]   <= pipe_v[i-1];
                pipe_idx[i] <= pipe_idx[i-1];
            end
        end
    end

endmodule
